// File: rtl/plazer_st_pkg.sv
`default_nettype none
// ============================================================================
// Module  : plazer_st_pkg
// Brief   : Marker codes and decoder state shared by the byte/packet converters
// Revision: 1.0
// ============================================================================
package plazer_st_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ESC      = 2'd1,
        CHAN     = 2'd2,
        CHAN_ESC = 2'd3
    } decoder_state_t;

endpackage
`default_nettype wire

// File: rtl/plazer_master_0_bytes_to_packets.sv
`default_nettype none
// ============================================================================
// Module  : plazer_master_0_bytes_to_packets
// Brief   : Decodes an escaped byte stream into channelised packet beats
// Revision: 1.0
// ============================================================================
module plazer_master_0_bytes_to_packets
    import plazer_st_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    decoder_state_t r_state;
    logic [7:0]     r_channel;
    logic           r_pending_sop;
    logic           r_pending_eop;

    logic           w_accept;
    logic           w_emit;
    logic [7:0]     w_emit_data;
    logic           w_set_sop;
    logic           w_set_eop;
    logic           w_chan_load;
    logic [7:0]     w_chan_data;
    decoder_state_t w_next_state;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_emit       = 1'b0;
        w_emit_data  = in_data;
        w_set_sop    = 1'b0;
        w_set_eop    = 1'b0;
        w_chan_load  = 1'b0;
        w_chan_data  = in_data;
        w_next_state = r_state;
        case (r_state)
            NORMAL, CHAN: begin
                if (r_state == CHAN && in_data == ESC_CHAR) begin
                    w_next_state = CHAN_ESC;
                end else begin
                    // A marker inside a channel sequence aborts it and is handled as in NORMAL
                    case (in_data)
                        SOP_CHAR: begin
                            w_set_sop    = 1'b1;
                            w_next_state = NORMAL;
                        end
                        EOP_CHAR: begin
                            w_set_eop    = 1'b1;
                            w_next_state = NORMAL;
                        end
                        CHAN_CHAR: w_next_state = CHAN;
                        ESC_CHAR:  w_next_state = ESC;
                        default: begin
                            if (r_state == NORMAL) begin
                                w_emit = 1'b1;
                            end else begin
                                w_chan_load  = 1'b1;
                                w_next_state = NORMAL;
                            end
                        end
                    endcase
                end
            end
            ESC: begin
                w_emit       = 1'b1;
                w_emit_data  = in_data ^ ESC_XOR;
                w_next_state = NORMAL;
            end
            CHAN_ESC: begin
                w_chan_load  = 1'b1;
                w_chan_data  = in_data ^ ESC_XOR;
                w_next_state = NORMAL;
            end
            default: w_next_state = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= NORMAL;
            r_channel         <= 8'h00;
            r_pending_sop     <= 1'b0;
            r_pending_eop     <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
        end else begin
            if (w_accept) begin
                r_state <= w_next_state;
                if (w_chan_load) begin
                    r_channel <= w_chan_data;
                end
            end
            if (w_accept && w_emit) begin
                out_valid         <= 1'b1;
                out_data          <= w_emit_data;
                out_startofpacket <= r_pending_sop;
                out_endofpacket   <= r_pending_eop;
                out_channel       <= r_channel[CHANNEL_WIDTH-1:0];
                r_pending_sop     <= 1'b0;
                r_pending_eop     <= 1'b0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (w_accept && w_set_sop) begin
                    r_pending_sop <= 1'b1;
                end
                if (w_accept && w_set_eop) begin
                    r_pending_eop <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
